// File: rtl/viterbi_chan_pkg.sv
// Shared types and constants for the burst-error channel model.
// Holds the FSM state type, the LFSR polynomial and two small helper functions.
package viterbi_chan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } chan_state_t;

    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_1234;

    // Right-shifting Galois step: the bit shifted out selects the tap XOR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/chan_lfsr.sv
// 32-bit Galois LFSR with a synchronous reseed and an advance enable.
// Reseed takes priority over advance.
module chan_lfsr
    import viterbi_chan_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reseed_i,
    input  logic        adv_i,
    output logic [31:0] state_o
);

    logic [31:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (reseed_i) begin
            lfsr_d = SEED;
        end else if (adv_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/burst_error_channel.sv
// Noisy channel: XORs random bursts of errors into code symbols inside a measurement window.
// Optional erasure flag output is built when CHANNEL_ERASURE_EN is defined.
module burst_error_channel
    import viterbi_chan_pkg::*;
#(
    parameter int unsigned SYM_W     = 2,
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned WINDOW    = 256,
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] SEED      = DEFAULT_SEED
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr_i,
    input  logic                             inj_en_i,
    input  logic [4:0]                       rate_i,
    input  logic [$clog2(BURST_MAX+1)-1:0]   burst_len_i,
    input  logic                             valid_i,
    input  logic [SYM_W-1:0]                 sym_i,
    output logic                             valid_o,
    output logic [SYM_W-1:0]                 sym_o,
    output logic [SYM_W-1:0]                 err_mask_o,
    output logic                             win_done_o,
    output logic [CNT_W-1:0]                 err_sym_ct_o,
    output logic [CNT_W-1:0]                 bad_bit_ct_o,
    output logic [$clog2(WINDOW+1)-1:0]      sym_ct_o
`ifdef CHANNEL_ERASURE_EN
    ,
    output logic                             erase_o
`endif
);

    localparam int unsigned LEN_W = $clog2(BURST_MAX + 1);
    localparam int unsigned CT_W  = $clog2(WINDOW + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    chan_state_t       state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [CT_W-1:0]   sym_ct_q, sym_ct_d;
    logic [CNT_W-1:0]  err_ct_q, err_ct_d;
    logic [CNT_W-1:0]  bit_ct_q, bit_ct_d;
    logic              valid_q, valid_d;
    logic [SYM_W-1:0]  sym_q, sym_d;
    logic [SYM_W-1:0]  mask_q, mask_d;

    logic              accept;
    logic [31:0]       lfsr;
    logic [31:0]       rate_mask;
    logic              trigger;
    logic [LEN_W-1:0]  len;
    logic [SYM_W-1:0]  rnd_mask;
    logic [SYM_W-1:0]  hit_mask;
    logic              corrupt;
    logic [SYM_W-1:0]  mask_sel;
    logic [SUM_W-1:0]  err_sum;
    logic [SUM_W-1:0]  bit_sum;

    assign accept = valid_i & ~clr_i;

    chan_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .reseed_i (clr_i),
        .adv_i    (accept),
        .state_o  (lfsr)
    );

    always_comb begin
        rate_mask = (32'd1 << rate_i) - 32'd1;
        trigger   = (rate_i != 5'd0) && ((lfsr & rate_mask) == rate_mask);

        if (burst_len_i == '0) begin
            len = LEN_W'(1);
        end else if (burst_len_i > LEN_W'(BURST_MAX)) begin
            len = LEN_W'(BURST_MAX);
        end else begin
            len = burst_len_i;
        end

        // An all-zero random mask would be a silent corruption, so force one flipped bit.
        rnd_mask = lfsr[SYM_W+7:8];
        hit_mask = (rnd_mask == '0) ? SYM_W'(1) : rnd_mask;
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        sym_ct_d = sym_ct_q;
        corrupt  = 1'b0;

        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (inj_en_i && trigger) begin
                        corrupt = 1'b1;
                        rem_d   = len - LEN_W'(1);
                        if (len != LEN_W'(1)) begin
                            state_d = BURST;
                        end
                    end
                end
                BURST: begin
                    if (!inj_en_i) begin
                        state_d = IDLE;
                        rem_d   = '0;
                    end else begin
                        corrupt = 1'b1;
                        rem_d   = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_d = IDLE;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // Window end overrides any burst still in progress.
            if (state_q != DONE) begin
                sym_ct_d = sym_ct_q + CT_W'(1);
                if (sym_ct_d == CT_W'(WINDOW)) begin
                    state_d = DONE;
                    rem_d   = '0;
                end
            end
        end

        if (clr_i) begin
            state_d  = IDLE;
            rem_d    = '0;
            sym_ct_d = '0;
        end
    end

    always_comb begin
        mask_sel = corrupt ? hit_mask : '0;
        err_sum  = {1'b0, err_ct_q} + SUM_W'(1);
        bit_sum  = {1'b0, bit_ct_q} + SUM_W'(popcount32(32'(mask_sel)));

        valid_d  = valid_i & ~clr_i;
        sym_d    = sym_q;
        mask_d   = mask_q;
        err_ct_d = err_ct_q;
        bit_ct_d = bit_ct_q;

        if (accept) begin
            sym_d  = sym_i ^ mask_sel;
            mask_d = mask_sel;
            if (corrupt) begin
                err_ct_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
                bit_ct_d = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
            end
        end

        if (clr_i) begin
            sym_d    = '0;
            mask_d   = '0;
            err_ct_d = '0;
            bit_ct_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            sym_ct_q <= '0;
            err_ct_q <= '0;
            bit_ct_q <= '0;
            valid_q  <= 1'b0;
            sym_q    <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            sym_ct_q <= sym_ct_d;
            err_ct_q <= err_ct_d;
            bit_ct_q <= bit_ct_d;
            valid_q  <= valid_d;
            sym_q    <= sym_d;
            mask_q   <= mask_d;
        end
    end

    assign valid_o      = valid_q;
    assign sym_o        = sym_q;
    assign err_mask_o   = mask_q;
    assign win_done_o   = (state_q == DONE);
    assign err_sym_ct_o = err_ct_q;
    assign bad_bit_ct_o = bit_ct_q;
    assign sym_ct_o     = sym_ct_q;

`ifdef CHANNEL_ERASURE_EN
    logic erase_q, erase_d;

    always_comb begin
        erase_d = erase_q;
        if (accept) begin
            erase_d = corrupt;
        end
        if (clr_i) begin
            erase_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            erase_q <= 1'b0;
        end else begin
            erase_q <= erase_d;
        end
    end

    assign erase_o = erase_q;
`endif

endmodule

// File: tb/tb_burst_error_channel.sv
// Randomised scoreboard bench for burst_error_channel against a behavioural channel model.
// Small WINDOW and CNT_W make window ends and counter saturation frequent.
module tb_burst_error_channel;

    localparam int unsigned SYM_W     = 2;
    localparam int unsigned BURST_MAX = 4;
    localparam int unsigned WINDOW    = 24;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned LEN_W     = $clog2(BURST_MAX + 1);
    localparam int unsigned CT_W      = $clog2(WINDOW + 1);
    localparam int          SAT       = (1 << CNT_W) - 1;
    localparam logic [31:0] SEED      = 32'hACE1_1234;

    typedef struct {
        logic [SYM_W-1:0] sym;
        logic [SYM_W-1:0] mask;
        int               err;
        int               bits;
        int               ct;
        bit               done;
        bit               erase;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  clr_i = 1'b0;
    logic                  inj_en_i = 1'b0;
    logic [4:0]            rate_i = '0;
    logic [LEN_W-1:0]      burst_len_i = '0;
    logic                  valid_i = 1'b0;
    logic [SYM_W-1:0]      sym_i = '0;
    logic                  valid_o;
    logic [SYM_W-1:0]      sym_o;
    logic [SYM_W-1:0]      err_mask_o;
    logic                  win_done_o;
    logic [CNT_W-1:0]      err_sym_ct_o;
    logic [CNT_W-1:0]      bad_bit_ct_o;
    logic [CT_W-1:0]       sym_ct_o;
`ifdef CHANNEL_ERASURE_EN
    logic                  erase_o;
`endif

    burst_error_channel #(
        .SYM_W     (SYM_W),
        .BURST_MAX (BURST_MAX),
        .WINDOW    (WINDOW),
        .CNT_W     (CNT_W),
        .SEED      (SEED)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (clr_i),
        .inj_en_i     (inj_en_i),
        .rate_i       (rate_i),
        .burst_len_i  (burst_len_i),
        .valid_i      (valid_i),
        .sym_i        (sym_i),
        .valid_o      (valid_o),
        .sym_o        (sym_o),
        .err_mask_o   (err_mask_o),
        .win_done_o   (win_done_o),
        .err_sym_ct_o (err_sym_ct_o),
        .bad_bit_ct_o (bad_bit_ct_o),
        .sym_ct_o     (sym_ct_o)
`ifdef CHANNEL_ERASURE_EN
        ,
        .erase_o      (erase_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t exp_q[$];

    // Requested configuration, copied onto the DUT inputs at the next drive.
    bit          cfg_inj  = 1'b1;
    int unsigned cfg_rate = 0;
    int unsigned cfg_len  = 4;

    // Reference model state: plain integers, not an FSM encoding.
    logic [31:0] m_lfsr;
    int          m_left;   // burst symbols still owed after the current one
    int          m_ct;
    int          m_err;
    int          m_bits;
    bit          m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] next_lfsr(input logic [31:0] s);
        logic [31:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ 32'h8020_0003;
        return t;
    endfunction

    task automatic model_reset();
        m_lfsr = SEED;
        m_left = 0;
        m_ct   = 0;
        m_err  = 0;
        m_bits = 0;
        m_done = 1'b0;
    endtask

    task automatic model_sym(input logic [SYM_W-1:0] s);
        exp_t        e;
        bit          trig;
        bit          corrupt;
        int unsigned modulus;
        int unsigned eff_len;
        int unsigned rnd;
        logic [SYM_W-1:0] m;

        modulus = 32'd1 << cfg_rate;
        trig    = (cfg_rate != 0) && ((m_lfsr % modulus) == modulus - 1);
        eff_len = (cfg_len == 0) ? 1 : ((cfg_len > BURST_MAX) ? BURST_MAX : cfg_len);
        corrupt = 1'b0;
        if (!m_done) begin
            if (m_left > 0) begin
                if (cfg_inj) begin
                    corrupt = 1'b1;
                    m_left--;
                end else begin
                    m_left = 0;
                end
            end else if (cfg_inj && trig) begin
                corrupt = 1'b1;
                m_left  = eff_len - 1;
            end
        end
        rnd = (m_lfsr >> 8) % (1 << SYM_W);
        m   = corrupt ? ((rnd == 0) ? SYM_W'(1) : SYM_W'(rnd)) : '0;
        if (corrupt) begin
            m_err  = (m_err + 1 > SAT) ? SAT : m_err + 1;
            m_bits = (m_bits + $countones(m) > SAT) ? SAT : m_bits + $countones(m);
        end
        if (!m_done) begin
            m_ct++;
            if (m_ct == WINDOW) begin
                m_done = 1'b1;
                m_left = 0;
            end
        end
        m_lfsr  = next_lfsr(m_lfsr);
        e.sym   = s ^ m;
        e.mask  = m;
        e.err   = m_err;
        e.bits  = m_bits;
        e.ct    = m_ct;
        e.done  = m_done;
        e.erase = corrupt;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit v, input logic [SYM_W-1:0] s, input bit c);
        @(negedge clk);
        inj_en_i    = cfg_inj;
        rate_i      = 5'(cfg_rate);
        burst_len_i = LEN_W'(cfg_len);
        valid_i     = v;
        sym_i       = s;
        clr_i       = c;
        if (c) begin
            model_reset();
        end else if (v) begin
            model_sym(s);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid_i = 1'b0;
        clr_i   = 1'b0;
        rst     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: pops one expected entry per valid_o, otherwise checks that outputs hold.
    initial begin : monitor
        exp_t hold;
        exp_t e;
        bit   r;
        bit   c;
        hold = '{sym: '0, mask: '0, err: 0, bits: 0, ct: 0, done: 1'b0, erase: 1'b0};
        forever begin
            @(posedge clk);
            r = rst;
            c = clr_i;
            #1;
            if (!r || c) begin
                chk("clear_valid", 32'(valid_o), 32'd0);
                chk("clear_sym", 32'(sym_o), 32'd0);
                chk("clear_mask", 32'(err_mask_o), 32'd0);
                chk("clear_done", 32'(win_done_o), 32'd0);
                chk("clear_err_ct", 32'(err_sym_ct_o), 32'd0);
                chk("clear_bit_ct", 32'(bad_bit_ct_o), 32'd0);
                chk("clear_sym_ct", 32'(sym_ct_o), 32'd0);
                hold = '{sym: '0, mask: '0, err: 0, bits: 0, ct: 0, done: 1'b0, erase: 1'b0};
            end else if (valid_o) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_valid: got valid_o=1, expected no output at %0t",
                             $time);
                end else begin
                    n_pass++;
                    e = exp_q.pop_front();
                    chk("sym_o", 32'(sym_o), 32'(e.sym));
                    chk("err_mask_o", 32'(err_mask_o), 32'(e.mask));
                    chk("err_sym_ct_o", 32'(err_sym_ct_o), 32'(e.err));
                    chk("bad_bit_ct_o", 32'(bad_bit_ct_o), 32'(e.bits));
                    chk("sym_ct_o", 32'(sym_ct_o), 32'(e.ct));
                    chk("win_done_o", 32'(win_done_o), 32'(e.done));
`ifdef CHANNEL_ERASURE_EN
                    chk("erase_o", 32'(erase_o), 32'(e.erase));
                    chk("erase_vs_mask", 32'(erase_o), 32'(|err_mask_o));
`endif
                    hold = e;
                end
            end else begin
                chk("hold_sym", 32'(sym_o), 32'(hold.sym));
                chk("hold_mask", 32'(err_mask_o), 32'(hold.mask));
                chk("hold_err_ct", 32'(err_sym_ct_o), 32'(hold.err));
                chk("hold_bit_ct", 32'(bad_bit_ct_o), 32'(hold.bits));
                chk("hold_sym_ct", 32'(sym_ct_o), 32'(hold.ct));
                chk("hold_done", 32'(win_done_o), 32'(hold.done));
            end
        end
    end

    initial begin : stimulus
        int guard;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) drive(1'b0, '0, 1'b0);

        // No triggers: clean pass-through, window closes at WINDOW symbols.
        cfg_inj  = 1'b1;
        cfg_rate = 0;
        cfg_len  = 4;
        for (int i = 0; i < WINDOW + 16; i++) drive(1'b1, SYM_W'(i % 4), 1'b0);
        repeat (2) drive(1'b0, '0, 1'b0);

        // Frequent triggers with maximum bursts.
        drive(1'b0, '0, 1'b1);
        cfg_rate = 1;
        cfg_len  = 4;
        for (int i = 0; i < WINDOW + 16; i++) drive(1'b1, SYM_W'($urandom), 1'b0);

        // Alternating valid, then reset mid-burst and a mid-window clear.
        drive(1'b0, '0, 1'b1);
        cfg_rate = 2;
        cfg_len  = 3;
        for (int i = 0; i < 2 * WINDOW + 8; i++) drive(i[0] == 1'b0, SYM_W'($urandom), 1'b0);
        drive(1'b0, '0, 1'b1);
        cfg_rate = 1;
        guard    = 0;
        while (m_left == 0 && guard < 4 * WINDOW) begin
            drive(1'b1, SYM_W'($urandom), 1'b0);
            guard++;
        end
        do_reset();
        for (int i = 0; i < WINDOW / 2; i++) drive(1'b1, SYM_W'(i), 1'b0);
        drive(1'b1, 2'b11, 1'b1);
        for (int i = 0; i < WINDOW + 4; i++) drive(1'b1, SYM_W'(i), 1'b0);

        // Long random run: clamped/zero lengths, injection toggling, sporadic clears/resets.
        for (int i = 0; i < 4000; i++) begin
            if (i % 20 == 0) begin
                cfg_rate = $urandom_range(0, 4);
                cfg_len  = $urandom_range(0, (1 << LEN_W) - 1);
            end
            cfg_inj = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 3) != 0, SYM_W'($urandom),
                      $urandom_range(0, 59) == 0);
            end
        end

        repeat (4) drive(1'b0, '0, 1'b0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
